dat_xfer_sequencer: RTL

- Host-side controller that sequences multi-block DAT transfers, read and write, after the command response arrives.
- Decides when the DAT line engine may start each block: checks Tx FIFO fill (write) or Rx FIFO free space (read) against the block size.
- Counts blocks and inserts the inter-block gap.
- Reports completion or error to the register file.
- Sits in the host_clk domain between the register block, the Tx/Rx FIFOs and the DAT PHY.

---
 rtl/dat_xfer_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dat_xfer_sequencer.sv
// Host-side DAT transfer sequencer: gates each block on FIFO fill/free space,
// counts blocks, inserts the inter-block gap. Optional watchdog: DAT_SEQ_TIMEOUT_EN.
module dat_xfer_sequencer #(
  parameter int BLOCK_SZ_WIDTH  = 12,
  parameter int BLOCK_CNT_WIDTH = 16,
  parameter int FIFO_LVL_WIDTH  = 6,
  parameter int GAP_CYCLES      = 8,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       host_clk,
  input  logic                       rst,
  input  logic                       resp_recv,
  input  logic                       abort,
  input  logic [BLOCK_SZ_WIDTH-1:0]  block_sz_reg,
  input  logic [BLOCK_CNT_WIDTH-1:0] block_cnt_reg,
  input  logic                       multiple_blk_reg,
  input  logic                       tf_direction_reg,
  input  logic [FIFO_LVL_WIDTH-1:0]  tx_buf_level,
  input  logic [FIFO_LVL_WIDTH-1:0]  rx_buf_free,
  input  logic                       phy_blk_done,
  input  logic                       phy_crc_err,
  output logic                       phy_start_wr,
  output logic                       phy_start_rd,
  output logic                       phy_abort,
  output logic                       busy,
  output logic [BLOCK_CNT_WIDTH-1:0] blk_remaining,
  output logic                       xfer_complete,
  output logic                       xfer_error,
  output logic [1:0]                 err_code
);

  // One extra bit so (block_sz_reg + 3) cannot wrap before the shift.
  localparam int WW = BLOCK_SZ_WIDTH + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CRC     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_XFER,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                     state_q, state_d;
  logic                       dir_q, dir_d;
  logic [WW-1:0]              words_q, words_d;
  logic [BLOCK_CNT_WIDTH-1:0] blk_q, blk_d;
  logic [1:0]                 err_q, err_d;
  logic [GW-1:0]              gap_q, gap_d;
  logic                       start_wr_d, start_rd_d, abort_d, cmpl_d, xerr_d;
  logic [WW-1:0]              words_calc;
  logic                       fifo_ok;

`ifdef DAT_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_q, to_d;
`endif

  assign words_calc = ({1'b0, block_sz_reg} + WW'(3)) >> 2;

  assign fifo_ok = dir_q ? (WW'(rx_buf_free)  >= words_q)
                         : (WW'(tx_buf_level) >= words_q);

  assign busy          = (state_q != S_IDLE);
  assign blk_remaining = blk_q;
  assign err_code      = err_q;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    words_d    = words_q;
    blk_d      = blk_q;
    err_d      = err_q;
    gap_d      = gap_q;
    start_wr_d = 1'b0;
    start_rd_d = 1'b0;
    abort_d    = 1'b0;
    cmpl_d     = 1'b0;
    xerr_d     = 1'b0;
`ifdef DAT_SEQ_TIMEOUT_EN
    to_d       = to_q;
`endif

    if (abort && (state_q != S_IDLE)) begin
      // Abort outranks any block completion or FIFO condition in the same cycle.
      state_d = S_IDLE;
      abort_d = 1'b1;
      xerr_d  = 1'b1;
      err_d   = ERR_ABORT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (resp_recv) begin
            dir_d   = tf_direction_reg;
            words_d = words_calc;
            blk_d   = multiple_blk_reg ? block_cnt_reg : BLOCK_CNT_WIDTH'(1);
            err_d   = ERR_NONE;
            if (multiple_blk_reg && (block_cnt_reg == '0)) state_d = S_DONE;
            else                                           state_d = S_CHECK;
          end
        end

        S_CHECK: begin
          if (fifo_ok) begin
            start_wr_d = ~dir_q;
            start_rd_d = dir_q;
            state_d    = S_XFER;
`ifdef DAT_SEQ_TIMEOUT_EN
            to_d       = '0;
`endif
          end
        end

        S_XFER: begin
          if (phy_blk_done) begin
            if (phy_crc_err) begin
              err_d   = ERR_CRC;
              state_d = S_ERROR;
            end else begin
              blk_d   = blk_q - BLOCK_CNT_WIDTH'(1);
              gap_d   = '0;
              state_d = (blk_q == BLOCK_CNT_WIDTH'(1)) ? S_DONE : S_GAP;
            end
          end
`ifdef DAT_SEQ_TIMEOUT_EN
          else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            abort_d = 1'b1;
            err_d   = ERR_TIMEOUT;
            state_d = S_ERROR;
          end else begin
            to_d = to_q + TW'(1);
          end
`endif
        end

        S_GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_CHECK;
          else                              gap_d   = gap_q + GW'(1);
        end

        S_DONE: begin
          cmpl_d  = 1'b1;
          state_d = S_IDLE;
        end

        S_ERROR: begin
          xerr_d  = 1'b1;
          state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge host_clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dir_q         <= 1'b0;
      words_q       <= '0;
      blk_q         <= '0;
      err_q         <= ERR_NONE;
      gap_q         <= '0;
      phy_start_wr  <= 1'b0;
      phy_start_rd  <= 1'b0;
      phy_abort     <= 1'b0;
      xfer_complete <= 1'b0;
      xfer_error    <= 1'b0;
`ifdef DAT_SEQ_TIMEOUT_EN
      to_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      words_q       <= words_d;
      blk_q         <= blk_d;
      err_q         <= err_d;
      gap_q         <= gap_d;
      phy_start_wr  <= start_wr_d;
      phy_start_rd  <= start_rd_d;
      phy_abort     <= abort_d;
      xfer_complete <= cmpl_d;
      xfer_error    <= xerr_d;
`ifdef DAT_SEQ_TIMEOUT_EN
      to_q          <= to_d;
`endif
    end
  end

endmodule
